raster_scan_counter: RTL

Parametrised single-clock raster position generator producing (col, row) coordinates for a configurable frame of up to MAX_COLS × MAX_ROWS pixels. It steps through pixels with a valid/ready handshake so downstream stages can stall it, and flags line and frame boundaries. It supports single-frame and continuous modes. It sits at the front of the pixel pipeline, driving address generation for frame buffers and the detection front end.

---
 rtl/raster_scan_counter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/raster_scan_counter.sv
// raster_scan_counter
//   Raster (col,row) position generator with a valid/ready handshake. Walks a
//   cols x rows frame one coordinate per accepted beat, flags line and frame
//   boundaries, and runs either one frame or continuously until abort.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-low reset
//   start       begin a scan (honoured only when idle)
//   abort       synchronous stop, back to idle from any state
//   continuous  sampled with start: 1 = wrap frames, 0 = single frame
//   cfg_cols    frame width, sampled with start (0 or > MAX_COLS -> MAX_COLS)
//   cfg_rows    frame height, sampled with start (0 or > MAX_ROWS -> MAX_ROWS)
//   ready       downstream accepts the current coordinate
//   valid       col/row are meaningful
//   col, row    current coordinate
//   sol, eol    start / end of line (combinational, qualified by valid)
//   sof, eof    first / last pixel of frame (combinational, qualified by valid)
//   busy        not idle
//   done        one-cycle pulse after the last pixel of a single-mode frame
//   frame_cnt   frames completed since reset (wraps)

module raster_scan_counter #(
  parameter int unsigned MAX_COLS = 640,
  parameter int unsigned MAX_ROWS = 640,
  parameter int unsigned COL_W    = 10,
  parameter int unsigned ROW_W    = 10,
  parameter int unsigned FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [COL_W-1:0]   cfg_cols,
  input  logic [ROW_W-1:0]   cfg_rows,
  input  logic               ready,
  output logic               valid,
  output logic [COL_W-1:0]   col,
  output logic [ROW_W-1:0]   row,
  output logic               sol,
  output logic               eol,
  output logic               sof,
  output logic               eof,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] frame_cnt
);

  // Frame extents are stored as last index (size - 1) so MAX fits in COL_W/ROW_W.
  localparam logic [COL_W-1:0] MAX_COL_IDX = COL_W'(MAX_COLS - 1);
  localparam logic [ROW_W-1:0] MAX_ROW_IDX = ROW_W'(MAX_ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               valid_d;
  logic [COL_W-1:0]   col_d;
  logic [ROW_W-1:0]   row_d;
  logic               busy_d;
  logic               done_d;
  logic [FRAME_W-1:0] frame_cnt_d;
  logic [COL_W-1:0]   last_col_q, last_col_d;
  logic [ROW_W-1:0]   last_row_q, last_row_d;
  logic               cont_q, cont_d;

  logic [COL_W-1:0]   cfg_last_col;
  logic [ROW_W-1:0]   cfg_last_row;
  logic               accept;
  logic               at_last_col;
  logic               at_last_row;

  // Sanitise requested size: 0 or oversize selects the maximum frame.
  always_comb begin
    cfg_last_col = MAX_COL_IDX;
    cfg_last_row = MAX_ROW_IDX;
    if ((cfg_cols != '0) && (32'(cfg_cols) <= MAX_COLS)) begin
      cfg_last_col = cfg_cols - COL_W'(1);
    end
    if ((cfg_rows != '0) && (32'(cfg_rows) <= MAX_ROWS)) begin
      cfg_last_row = cfg_rows - ROW_W'(1);
    end
  end

  assign accept      = valid && ready;
  assign at_last_col = (col == last_col_q);
  assign at_last_row = (row == last_row_q);

  // Boundary flags decoded from registered position.
  assign sol = valid && (col == '0);
  assign eol = valid && at_last_col;
  assign sof = valid && (col == '0) && (row == '0);
  assign eof = valid && at_last_col && at_last_row;

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      valid      <= 1'b0;
      col        <= '0;
      row        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      frame_cnt  <= '0;
      last_col_q <= MAX_COL_IDX;
      last_row_q <= MAX_ROW_IDX;
      cont_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid      <= valid_d;
      col        <= col_d;
      row        <= row_d;
      busy       <= busy_d;
      done       <= done_d;
      frame_cnt  <= frame_cnt_d;
      last_col_q <= last_col_d;
      last_row_q <= last_row_d;
      cont_q     <= cont_d;
    end
  end

  // Next-state and next-output logic; abort overrides everything.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid;
    col_d       = col;
    row_d       = row;
    busy_d      = busy;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt;
    last_col_d  = last_col_q;
    last_row_d  = last_row_q;
    cont_d      = cont_q;

    if (abort) begin
      // Position is left where it was; no frame credit, no done pulse.
      state_d = ST_IDLE;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            last_col_d = cfg_last_col;
            last_row_d = cfg_last_row;
            cont_d     = continuous;
            col_d      = '0;
            row_d      = '0;
            state_d    = ST_SCAN;
            valid_d    = 1'b1;
            busy_d     = 1'b1;
          end
        end
        ST_SCAN: begin
          if (accept) begin
            if (at_last_col) begin
              col_d = '0;
              if (at_last_row) begin
                row_d       = '0;
                frame_cnt_d = frame_cnt + FRAME_W'(1);
                if (!cont_q) begin
                  state_d = ST_DONE;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                end
              end else begin
                row_d = row + ROW_W'(1);
              end
            end else begin
              col_d = col + COL_W'(1);
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

endmodule
